axis_gen_frame_scheduler: RTL and testbench
===========================================

// Module: axis_gen_frame_scheduler
// PURPOSE
//  Sequencer for the AXIS counter-pattern data generator. On start, emits frame_num frames
//  of frame_len beats each, with gap idle cycles between frames.
//  - Drives the generator's enable, tdata source and tlast source.
//  - Observes its counter-enable (tready) to count accepted beats.
//  - Reports busy, done and frames sent to the control/status logic.
// PARAMETERS
//  AXIS_DATA_WIDTH  32  generator tdata width; gen_data_o width
//  LEN_WIDTH        16  width of frame_len_i / beat counter
//  NUM_WIDTH        16  width of frame_num_i / frame counter
//  GAP_WIDTH         8  width of gap_i / gap counter
// PORTS
//  clk_i           in   1                single clock
//  s_rst_i         in   1                reset, synchronous, active-high
//  start_i         in   1                1-cycle start pulse; honoured only in IDLE
//  stop_i          in   1                graceful stop request; ends after current frame
//  frame_len_i     in   LEN_WIDTH        beats per frame; 0 is illegal
//  frame_num_i     in   NUM_WIDTH        frames per run; 0 = continuous until stop
//  gap_i           in   GAP_WIDTH        idle cycles between frames; 0 = back-to-back
//  gen_cntr_en_i   in   1                generator counter enable (= tready)
//  gen_enable_o    out  1                generator enable (= tvalid)
//  gen_data_o      out  AXIS_DATA_WIDTH  word to transmit
//  gen_terminal_o  out  1                last beat of frame (= tlast)
//  busy_o          out  1                high from the cycle after accepted start until DONE
//  done_o          out  1                1-cycle pulse when a run ends
//  cfg_err_o       out  1                1-cycle pulse: start_i with frame_len_i == 0
//  frame_cnt_o     out  NUM_WIDTH        frames completed in current/last run
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; every counter 0; stop_pending 0.
//  - Reset mid-frame aborts at the next edge; the frame is truncated, downstream is reset too.
//  - Outputs decode only registered state/counters; no combinational path from any input.
//  - Beat accepted when gen_enable_o && gen_cntr_en_i.
//  - FSM states: IDLE, SEND, GAP, DONE.
//  - IDLE, start_i=1, len != 0:
//    - latch len_q, num_q, gap_q
//    - clear beat_cnt, word_cnt, frame_cnt
//    - stop_pending <= stop_i
//    - -> SEND; gen_enable_o high one cycle after start.
//  - IDLE, start_i=1, len = 0: cfg_err_o pulses next cycle; stay IDLE.
//  - stop_i in IDLE ignored unless coincident with a valid start (then exactly one frame is sent).
//  - start_i outside IDLE is ignored; latched config never changes during a run.
//  - SEND:
//    - gen_enable_o=1, held while gen_cntr_en_i=0; gen_data_o and gen_terminal_o stable until accept.
//    - gen_data_o = word_cnt; increments per accepted beat, runs across frames, wraps mod 2^AXIS_DATA_WIDTH.
//    - gen_terminal_o = (beat_cnt == len_q-1); len_q=1 gives tlast on every beat.
//    - stop_i sets stop_pending.
//  - SEND, accept with terminal:
//    - beat_cnt <= 0; frame_cnt++ (wraps in continuous mode).
//    - stop_pending, or (num_q != 0 and frame_cnt+1 == num_q) -> DONE.
//    - else gap_q == 0 -> stay SEND; next beat is issued with no bubble.
//    - else -> GAP.
//  - GAP:
//    - gen_enable_o=0 for exactly gap_q cycles, then -> SEND.
//    - stop_i or stop_pending -> DONE on the next edge.
//  - DONE: one cycle; done_o=1, busy_o=0; clear stop_pending; -> IDLE. frame_cnt_o holds until next start.
//  - A frame is never truncated by stop_i; only reset truncates.
// STRUCTURE
//  - Shared header axis_gen_defs.vh: FSM state encodings, STATE_WIDTH, default widths
//    (shared with the generator).
//  - Sub-module axis_gen_beat_cntr: beat counter with load/clear, enable and terminal compare
//    (len_q-1). Gap and word counters stay inline.
// TESTING
//  - len=4, num=2, gap=0, ready=1: 8 beats, data 0..7, tlast on data 3 and 7; done one cycle
//    after beat 7; frame_cnt_o=2.
//  - len=3, num=2, gap=5: tvalid low exactly 5 cycles between tlast(data 2) and data 3.
//  - len=4, num=1, ready toggled 1,0,0,1,...: tvalid stays high; data/tlast hold during ready=0;
//    4 accepts total.
//  - num=0, len=2, stop_i mid-beat 1 of frame 3: frame 3 completes, done_o follows;
//    frame_cnt_o=3, no partial frame.
//  - start_i with frame_len_i=0 -> cfg_err_o pulse, busy_o stays 0.
//  - start_i and stop_i same cycle (len=5, num=10) -> exactly 5 beats.
//  - s_rst_i in SEND beat 2 -> next cycle all outputs 0, state IDLE.
//  - Restart: next start -> data restarts at 0.

Source files
------------

// File: rtl/axis_gen_frame_scheduler_pkg.sv
// Shared definitions for the AXIS counter-pattern generator frame scheduler:
// scheduler FSM state encoding and default datapath widths (also used by the
// generator side).
package axis_gen_frame_scheduler_pkg;

    localparam int unsigned AXIS_DATA_WIDTH_DEF = 32;
    localparam int unsigned LEN_WIDTH_DEF       = 16;
    localparam int unsigned NUM_WIDTH_DEF       = 16;
    localparam int unsigned GAP_WIDTH_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/axis_gen_frame_scheduler_beat_cntr.sv
// Beat-within-frame counter for the frame scheduler.
// Ports:
//   clk_i      - clock
//   s_rst_i    - synchronous active-high reset
//   clr_i      - synchronous clear (start of run); wins over en_i
//   en_i       - count one accepted beat
//   len_i      - frame length in beats (latched config, never 0 during a run)
//   terminal_o - current beat is the last beat of the frame (count == len_i-1)
module axis_gen_beat_cntr
    import axis_gen_frame_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH = LEN_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             s_rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] len_i,
    output logic             terminal_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign terminal_o = (cnt_q == (len_i - WIDTH'(1)));

    // Accepting the terminal beat wraps the counter back to 0 for the next frame.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = terminal_o ? '0 : (cnt_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_gen_frame_scheduler.sv
// Frame sequencer for the AXIS counter-pattern data generator. On start it
// emits frame_num frames of frame_len beats with gap idle cycles in between.
// Ports:
//   clk_i, s_rst_i        - clock, synchronous active-high reset
//   start_i, stop_i       - run start pulse (IDLE only) / graceful stop request
//   frame_len_i           - beats per frame (0 rejected with cfg_err_o)
//   frame_num_i           - frames per run (0 = continuous until stop)
//   gap_i                 - idle cycles between frames
//   gen_cntr_en_i         - generator counter enable (tready)
//   gen_enable_o          - generator enable (tvalid)
//   gen_data_o            - word to transmit (running word counter)
//   gen_terminal_o        - last beat of frame (tlast)
//   busy_o, done_o        - run active / one-cycle end-of-run pulse
//   cfg_err_o             - one-cycle pulse on start with zero length
//   frame_cnt_o           - frames completed in current/last run
// All outputs decode registered state only.
module axis_gen_frame_scheduler
    import axis_gen_frame_scheduler_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH       = LEN_WIDTH_DEF,
    parameter int unsigned NUM_WIDTH       = NUM_WIDTH_DEF,
    parameter int unsigned GAP_WIDTH       = GAP_WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       s_rst_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [LEN_WIDTH-1:0]       frame_len_i,
    input  logic [NUM_WIDTH-1:0]       frame_num_i,
    input  logic [GAP_WIDTH-1:0]       gap_i,
    input  logic                       gen_cntr_en_i,
    output logic                       gen_enable_o,
    output logic [AXIS_DATA_WIDTH-1:0] gen_data_o,
    output logic                       gen_terminal_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       cfg_err_o,
    output logic [NUM_WIDTH-1:0]       frame_cnt_o
);

    sched_state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic [NUM_WIDTH-1:0]       num_q, num_d;
    logic [GAP_WIDTH-1:0]       gap_q, gap_d;
    logic [GAP_WIDTH-1:0]       gap_cnt_q, gap_cnt_d;
    logic [AXIS_DATA_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [NUM_WIDTH-1:0]       frame_cnt_q, frame_cnt_d;
    logic                       stop_pend_q, stop_pend_d;
    logic                       cfg_err_q, cfg_err_d;

    logic                       beat_clr;
    logic                       beat_term;
    logic                       accept;
    logic [NUM_WIDTH-1:0]       frame_inc;

    assign accept    = (state_q == ST_SEND) && gen_cntr_en_i;
    assign frame_inc = frame_cnt_q + NUM_WIDTH'(1);

    axis_gen_beat_cntr #(
        .WIDTH (LEN_WIDTH)
    ) u_beat_cntr (
        .clk_i      (clk_i),
        .s_rst_i    (s_rst_i),
        .clr_i      (beat_clr),
        .en_i       (accept),
        .len_i      (len_q),
        .terminal_o (beat_term)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        stop_pend_d = stop_pend_q;
        cfg_err_d   = 1'b0;
        beat_clr    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (frame_len_i != '0) begin
                        len_d       = frame_len_i;
                        num_d       = frame_num_i;
                        gap_d       = gap_i;
                        word_cnt_d  = '0;
                        frame_cnt_d = '0;
                        stop_pend_d = stop_i;
                        beat_clr    = 1'b1;
                        state_d     = ST_SEND;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    word_cnt_d = word_cnt_q + AXIS_DATA_WIDTH'(1);
                    if (beat_term) begin
                        frame_cnt_d = frame_inc;
                        // A stop raised on the terminal beat itself still ends the
                        // run after this frame rather than one frame later.
                        if (stop_pend_q || stop_i ||
                            ((num_q != '0) && (frame_inc == num_q))) begin
                            state_d = ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_cnt_d = '0;
                            state_d   = ST_GAP;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (stop_i || stop_pend_q) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == (gap_q - GAP_WIDTH'(1))) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                end
            end

            ST_DONE: begin
                stop_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
            stop_pend_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            stop_pend_q <= stop_pend_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign gen_enable_o   = (state_q == ST_SEND);
    assign gen_data_o     = word_cnt_q;
    assign gen_terminal_o = (state_q == ST_SEND) && beat_term;
    assign busy_o         = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done_o         = (state_q == ST_DONE);
    assign cfg_err_o      = cfg_err_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_axis_gen_frame_scheduler.sv
module tb_axis_gen_frame_scheduler;

    logic        clk = 1'b0;
    logic        s_rst_i;
    logic        start_i;
    logic        stop_i;
    logic [15:0] frame_len_i;
    logic [15:0] frame_num_i;
    logic [7:0]  gap_i;
    logic        gen_cntr_en_i;
    logic        gen_enable_o;
    logic [31:0] gen_data_o;
    logic        gen_terminal_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;
    logic [15:0] frame_cnt_o;

    int total = 0;
    int bad   = 0;

    axis_gen_frame_scheduler #(
        .AXIS_DATA_WIDTH (32),
        .LEN_WIDTH       (16),
        .NUM_WIDTH       (16),
        .GAP_WIDTH       (8)
    ) dut (
        .clk_i          (clk),
        .s_rst_i        (s_rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .frame_len_i    (frame_len_i),
        .frame_num_i    (frame_num_i),
        .gap_i          (gap_i),
        .gen_cntr_en_i  (gen_cntr_en_i),
        .gen_enable_o   (gen_enable_o),
        .gen_data_o     (gen_data_o),
        .gen_terminal_o (gen_terminal_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, gen_enable_o, 0);
        check({tag, "_data"}, gen_data_o, 0);
        check({tag, "_tlast"}, gen_terminal_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_cfgerr"}, cfg_err_o, 0);
        check({tag, "_fcnt"}, frame_cnt_o, 0);
    endtask

    // Transaction-level reference: words count up from 0 across the run, every
    // len-th accepted beat is tlast, gap idle cycles follow each non-final
    // frame, and the run ends one cycle after the final frame's tlast accept.
    // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
    // stop_at: accept index during whose beat stop_i is raised (-1 = none).
    task automatic run(input int len, input int num, input int gap, input int rmode,
                       input int stop_at, input bit stop_with_start);
        int  exp_word = 0;
        int  beat     = 0;
        int  frames   = 0;
        int  gap_left = 0;
        int  accepts  = 0;
        int  sc       = 0;
        int  cyc      = 0;
        int  stop_idx = stop_at;
        bit  stopping = stop_with_start;
        bit  end_next = 0;
        bit  finished = 0;
        bit  r;

        start_i       = 1'b1;
        frame_len_i   = 16'(len);
        frame_num_i   = 16'(num);
        gap_i         = 8'(gap);
        stop_i        = stop_with_start;
        gen_cntr_en_i = 1'b0;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("busy_after_start", busy_o, 1);

        while (!finished) begin
            // Start requests and config changes during a run must have no effect.
            start_i     = ($urandom_range(0, 5) == 0);
            frame_len_i = 16'($urandom_range(0, 9));
            frame_num_i = 16'($urandom_range(0, 9));
            gap_i       = 8'($urandom_range(0, 9));
            stop_i      = 1'b0;
            if (end_next) begin
                check("done_pulse", done_o, 1);
                check("done_busy", busy_o, 0);
                check("done_tvalid", gen_enable_o, 0);
                check("done_fcnt", frame_cnt_o, frames);
                gen_cntr_en_i = 1'b0;
                finished = 1;
            end else if (gap_left > 0) begin
                check("gap_tvalid", gen_enable_o, 0);
                check("gap_busy", busy_o, 1);
                gen_cntr_en_i = 1'($urandom_range(0, 1));
                gap_left--;
            end else begin
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = ((sc % 4) == 0) || ((sc % 4) == 3);
                    default: r = ($urandom_range(0, 2) != 0);
                endcase
                sc++;
                gen_cntr_en_i = r;
                check("send_tvalid", gen_enable_o, 1);
                check("send_data", gen_data_o, exp_word);
                check("send_tlast", gen_terminal_o, (beat == len - 1));
                check("send_done", done_o, 0);
                if (stop_idx >= 0 && accepts == stop_idx) begin
                    stop_i   = 1'b1;
                    stopping = 1;
                    stop_idx = -1;
                end
                if (r) begin
                    accepts++;
                    exp_word++;
                    beat++;
                    if (beat == len) begin
                        beat = 0;
                        frames++;
                        if (stopping || (num != 0 && frames == num)) end_next = 1;
                        else gap_left = gap;
                    end
                end
            end
            cyc++;
            if (!finished && cyc > 3000) begin
                check("run_timeout", 0, 1);
                finished = 1;
            end
            tick();
        end

        start_i = 1'b0;
        stop_i  = 1'b0;
        check("post_done_pulse", done_o, 0);
        check("post_done_busy", busy_o, 0);
        check("post_done_fcnt_hold", frame_cnt_o, frames);
        tick();
    endtask

    initial begin
        s_rst_i       = 1'b1;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        frame_len_i   = '0;
        frame_num_i   = '0;
        gap_i         = '0;
        gen_cntr_en_i = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        s_rst_i = 1'b0;
        tick();

        // 8 beats back to back, tlast on 3 and 7, frame_cnt 2.
        run(4, 2, 0, 0, -1, 0);
        // 5 idle cycles between frames.
        run(3, 2, 5, 0, -1, 0);
        // Backpressure: tvalid/data/tlast hold while ready low.
        run(4, 1, 0, 1, -1, 0);
        // Continuous mode, stop during the second beat of frame 3.
        run(2, 0, 0, 0, 5, 0);
        // Stop coincident with start: exactly one frame.
        run(5, 10, 0, 0, -1, 1);
        // Single-beat frames with a gap: tlast on every beat.
        run(1, 3, 2, 2, -1, 0);

        // Zero-length start is rejected.
        start_i     = 1'b1;
        frame_len_i = '0;
        frame_num_i = 16'd3;
        tick();
        start_i = 1'b0;
        check("cfgerr_pulse", cfg_err_o, 1);
        check("cfgerr_busy", busy_o, 0);
        check("cfgerr_tvalid", gen_enable_o, 0);
        tick();
        check("cfgerr_clear", cfg_err_o, 0);
        check("cfgerr_busy2", busy_o, 0);

        // Reset during beat 2 of a frame truncates it.
        start_i       = 1'b1;
        frame_len_i   = 16'd4;
        frame_num_i   = 16'd3;
        gap_i         = 8'd0;
        gen_cntr_en_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        check("prerst_data", gen_data_o, 2);
        s_rst_i = 1'b1;
        tick();
        check_all_zero("midrst");
        s_rst_i       = 1'b0;
        gen_cntr_en_i = 1'b0;
        tick();

        // Restart after reset: data begins at 0 again.
        run(3, 2, 1, 0, -1, 0);

        // Randomized runs.
        for (int i = 0; i < 8; i++) begin
            int len  = $urandom_range(1, 6);
            int num  = $urandom_range(0, 3);
            int gap  = $urandom_range(0, 3);
            int stop = (num == 0) ? $urandom_range(0, 3 * len) : -1;
            run(len, num, gap, 2, stop, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
